// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder response checker: FSM encoding and coverage-space sizing.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of distinct {a,b,ci} vectors for a given operand width.
  function automatic int vec_count(input int width);
    return 1 << (2 * width + 1);
  endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Golden combinational WIDTH-bit full adder used as the expected-value source.
module adder_ref_model #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] exp_sum,
  output logic             exp_carry
);

  always_comb begin
    {exp_carry, exp_sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  end

endmodule

// File: rtl/adder_response_checker.sv
// Two-stage response monitor: stage 1 captures the strobed sample, stage 2 compares
// it against the reference adder, updates saturating counters, first-fail capture and coverage.
module adder_response_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               sample_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               ci,
  input  logic [WIDTH-1:0]   sum,
  input  logic               carry,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic               err,
  output logic [2*WIDTH:0]   first_fail_vec,
  output logic [WIDTH:0]     first_fail_got,
  output logic               cov_full
);

  localparam int VEC_W = 2 * WIDTH + 1;
  localparam int NVEC  = vec_count(WIDTH);

  state_t state, state_nxt;

  logic             v1;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             ci_q, carry_q;
  logic [VEC_W-1:0] vec_q;
  logic [NVEC-1:0]  bitmap, bitmap_nxt;
  logic [WIDTH-1:0] exp_sum;
  logic             exp_carry;
  logic             match;
  logic             accept;

  assign accept = sample_valid && (state == RUN) && !start;
  assign vec_q  = {a_q, b_q, ci_q};

  adder_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a         (a_q),
    .b         (b_q),
    .ci        (ci_q),
    .exp_sum   (exp_sum),
    .exp_carry (exp_carry)
  );

  assign match = ({exp_carry, exp_sum} == {carry_q, sum_q});

  always_comb begin
    bitmap_nxt = bitmap;
    if (v1) begin
      bitmap_nxt[vec_q] = 1'b1;
    end
  end

  assign cov_full = &bitmap;
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  // Completing coverage ends the run on the same edge the last new vector is recorded.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (stop || (&bitmap_nxt)) state_nxt = DRAIN;
        DRAIN:   state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        ci_q    <= ci;
        sum_q   <= sum;
        carry_q <= carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      err            <= 1'b0;
      first_fail_vec <= '0;
      first_fail_got <= '0;
      bitmap         <= '0;
    end else if (start) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      err            <= 1'b0;
      first_fail_vec <= '0;
      first_fail_got <= '0;
      bitmap         <= '0;
    end else if (v1) begin
      bitmap <= bitmap_nxt;
      if (match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        if (!err) begin
          err            <= 1'b1;
          first_fail_vec <= vec_q;
          first_fail_got <= {carry_q, sum_q};
        end
      end
    end
  end

endmodule
